// File: rtl/host_uart_cmd_pkg.sv
// rtl/host_uart_cmd_pkg.sv - shared host UART command/response IDs, select codes, error and state encodings
package host_uart_cmd_pkg;

    localparam logic [7:0] CMD_ID_ENCRYPT_ENABLE = 8'h01;
    localparam logic [7:0] RSP_ID_ENCRYPT_ENABLE = 8'h02;
    localparam logic [7:0] CMD_ID_READ_YAW       = 8'h03;
    localparam logic [7:0] RSP_ID_READ_YAW       = 8'h04;

    localparam logic [15:0] SEL_ENCRYPT_ENABLE = 16'h0001;
    localparam logic [15:0] SEL_READ_YAW       = 16'h0002;

    localparam int CMD_DATA_W = 264;
    localparam int PAY_CNT_W  = 6;

    localparam logic [PAY_CNT_W-1:0] ENCRYPT_ENABLE_PAY_LEN = 6'd1;
    localparam logic [PAY_CNT_W-1:0] READ_YAW_PAY_LEN       = 6'd0;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_UNKNOWN_ID = 2'd1,
        ERR_TIMEOUT    = 2'd2
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DONE
    } cmd_state_e;

endpackage

// File: rtl/uart_byte_timeout.sv
// rtl/uart_byte_timeout.sv - inter-byte idle counter with clear, enable and expiry
module uart_byte_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // A transfer in the expiry cycle wins, so clear masks the expire output.
    assign expire_o = en_i && !clear_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (!en_i || clear_i) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/host_uart_command_dec.sv
// rtl/host_uart_command_dec.sv - assembles host command frames from UART RX bytes and holds the decoded command
module host_uart_command_dec
    import host_uart_cmd_pkg::*;
#(
    parameter int         HDR_BYTES             = 8,
    parameter logic [7:0] ENCRYPT_ENABLE_CMD_ID = CMD_ID_ENCRYPT_ENABLE,
    parameter logic [7:0] READ_YAW_CMD_ID       = CMD_ID_READ_YAW,
    parameter int         TIMEOUT_CYCLES        = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  cmd_valid,
    output logic [15:0]           cmd_select,
    output logic [CMD_DATA_W-1:0] cmd_data,
    input  logic                  cmd_ack,
    output logic                  busy,
    output logic                  error,
    output logic [1:0]            err_code
);

    localparam int HDR_CNT_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
    localparam logic [HDR_CNT_W-1:0] HDR_LAST = HDR_CNT_W'(HDR_BYTES - 1);

    cmd_state_e             state_q;
    logic [HDR_CNT_W-1:0]   hdr_cnt_q;
    logic [PAY_CNT_W-1:0]   pay_cnt_q;
    logic [PAY_CNT_W-1:0]   pay_len_q;
    logic                   unknown_q;
    logic [15:0]            sel_q;
    logic [CMD_DATA_W-1:0]  acc_q;
    logic                   rx_ready_q;
    logic                   cmd_valid_q;
    logic                   busy_q;
    logic                   error_q;
    err_code_e              err_code_q;

    logic [15:0]            id_sel_d;
    logic [PAY_CNT_W-1:0]   id_len_d;
    logic                   id_unknown_d;
    logic                   xfer;
    logic                   tmo_en;
    logic                   tmo_expire;

    assign xfer   = rx_valid && rx_ready_q;
    assign tmo_en = (state_q == ST_HDR) || (state_q == ST_PAYLOAD);

    always_comb begin
        id_sel_d     = '0;
        id_len_d     = '0;
        id_unknown_d = 1'b1;
        if (rx_byte == ENCRYPT_ENABLE_CMD_ID) begin
            id_sel_d     = SEL_ENCRYPT_ENABLE;
            id_len_d     = ENCRYPT_ENABLE_PAY_LEN;
            id_unknown_d = 1'b0;
        end else if (rx_byte == READ_YAW_CMD_ID) begin
            id_sel_d     = SEL_READ_YAW;
            id_len_d     = READ_YAW_PAY_LEN;
            id_unknown_d = 1'b0;
        end
    end

    uart_byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .en_i     (tmo_en),
        .clear_i  (xfer),
        .expire_o (tmo_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hdr_cnt_q   <= '0;
            pay_cnt_q   <= '0;
            pay_len_q   <= '0;
            unknown_q   <= 1'b0;
            sel_q       <= '0;
            acc_q       <= '0;
            rx_ready_q  <= 1'b1;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        sel_q     <= id_sel_d;
                        pay_len_q <= id_len_d;
                        unknown_q <= id_unknown_d;
                        acc_q     <= '0;
                        hdr_cnt_q <= HDR_CNT_W'(1);
                        pay_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        if (hdr_cnt_q == HDR_LAST) begin
                            hdr_cnt_q <= '0;
                            if (unknown_q) begin
                                error_q    <= 1'b1;
                                err_code_q <= ERR_UNKNOWN_ID;
                                busy_q     <= 1'b0;
                                state_q    <= ST_IDLE;
                            end else if (pay_len_q == '0) begin
                                cmd_valid_q <= 1'b1;
                                rx_ready_q  <= 1'b0;
                                state_q     <= ST_DONE;
                            end else begin
                                state_q <= ST_PAYLOAD;
                            end
                        end else begin
                            hdr_cnt_q <= hdr_cnt_q + 1'b1;
                        end
                    end else if (tmo_expire) begin
                        error_q    <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                        busy_q     <= 1'b0;
                        hdr_cnt_q  <= '0;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer) begin
                        acc_q[{pay_cnt_q, 3'b000} +: 8] <= rx_byte;
                        if (pay_cnt_q + 1'b1 == pay_len_q) begin
                            cmd_valid_q <= 1'b1;
                            rx_ready_q  <= 1'b0;
                            state_q     <= ST_DONE;
                        end else begin
                            pay_cnt_q <= pay_cnt_q + 1'b1;
                        end
                    end else if (tmo_expire) begin
                        error_q    <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (cmd_ack) begin
                        cmd_valid_q <= 1'b0;
                        rx_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Select and payload are only presented while a command is held.
    assign cmd_select = cmd_valid_q ? sel_q : '0;
    assign cmd_data   = cmd_valid_q ? acc_q : '0;
    assign cmd_valid  = cmd_valid_q;
    assign rx_ready   = rx_ready_q;
    assign busy       = busy_q;
    assign error      = error_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_host_uart_command_dec.sv
// tb/tb_host_uart_command_dec.sv - self-checking bench for host_uart_command_dec
module tb_host_uart_command_dec;

    localparam int HDR  = 8;
    localparam int TMO  = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic         rx_ready;
    logic         cmd_valid;
    logic [15:0]  cmd_select;
    logic [263:0] cmd_data;
    logic         cmd_ack;
    logic         busy;
    logic         error;
    logic [1:0]   err_code;

    int n_checks = 0;
    int n_fail   = 0;

    host_uart_command_dec #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .cmd_valid  (cmd_valid),
        .cmd_select (cmd_select),
        .cmd_data   (cmd_data),
        .cmd_ack    (cmd_ack),
        .busy       (busy),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [263:0] act, input logic [263:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: bytes of the open frame, idle cycles since its last byte, held command.
    logic [7:0]   m_frame[$];
    int           m_idle;
    bit           m_held;
    bit           m_err;
    logic [1:0]   m_code;
    logic [15:0]  m_sel;
    logic [263:0] m_data;

    function automatic bit id_known(input logic [7:0] id);
        return (id == 8'h01) || (id == 8'h03);
    endfunction

    function automatic int id_len(input logic [7:0] id);
        return (id == 8'h01) ? 1 : 0;
    endfunction

    function automatic logic [15:0] id_sel(input logic [7:0] id);
        return (id == 8'h01) ? 16'h1 : 16'h2;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_frame.delete();
            m_idle = 0;
            m_held = 0;
            m_err  = 0;
            m_code = 2'd0;
            m_sel  = '0;
            m_data = '0;
        end else begin
            m_err = 0;
            if (m_held) begin
                if (cmd_ack) m_held = 0;
            end else if (rx_valid) begin
                m_frame.push_back(rx_byte);
                m_idle = 0;
                if (m_frame.size() == HDR && !id_known(m_frame[0])) begin
                    m_err  = 1;
                    m_code = 2'd1;
                    m_frame.delete();
                end else if (m_frame.size() >= HDR && m_frame.size() == HDR + id_len(m_frame[0])) begin
                    m_held = 1;
                    m_sel  = id_sel(m_frame[0]);
                    m_data = '0;
                    for (int k = 0; k < id_len(m_frame[0]); k++) m_data[8*k +: 8] = m_frame[HDR+k];
                    m_frame.delete();
                end
            end else if (m_frame.size() > 0) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_err  = 1;
                    m_code = 2'd2;
                    m_idle = 0;
                    m_frame.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("m_cmd_valid", cmd_valid, m_held);
            chk("m_rx_ready", rx_ready, !m_held);
            chk("m_busy", busy, m_held || (m_frame.size() > 0));
            chk("m_error", error, m_err);
            chk("m_err_code", err_code, m_code);
            if (m_held) begin
                chk("m_cmd_select", cmd_select, m_sel);
                chk("m_cmd_data", cmd_data, m_data);
            end
        end
    end

    logic [7:0] tx_buf[0:15];
    int         tx_len;

    // Called and returns at posedge+1; leaves rx_valid low after the last accepted byte.
    task automatic send_buf(input bit toggle);
        int  idx   = 0;
        int  guard = 0;
        bit  acc;
        while (idx < tx_len && guard < 500) begin
            if (toggle && (guard % 2 == 1)) begin
                rx_valid = 1'b0;
            end else begin
                rx_valid = 1'b1;
                rx_byte  = tx_buf[idx];
            end
            acc = rx_valid && rx_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            guard++;
        end
        rx_valid = 1'b0;
        if (idx < tx_len) chk("send_guard", idx, tx_len);
    endtask

    task automatic load(input logic [7:0] id, input int n, input logic [7:0] pay);
        tx_buf[0] = id;
        for (int i = 1; i < 16; i++) tx_buf[i] = 8'h00;
        tx_buf[8] = pay;
        tx_len = n;
    endtask

    task automatic ack();
        cmd_ack = 1'b1;
        @(posedge clk); #1;
        cmd_ack = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_valid"}, cmd_valid, 1'b0);
        chk({tag, "_rx_ready"}, rx_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_error"}, error, 1'b0);
        chk({tag, "_err_code"}, err_code, 2'd0);
        chk({tag, "_cmd_select"}, cmd_select, 16'h0);
        chk({tag, "_cmd_data"}, cmd_data, 264'h0);
    endtask

    initial begin
        int cyc;
        reset    = 1'b1;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        cmd_ack  = 1'b0;
        #3;
        check_reset_vals("rst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: encrypt enable, back-to-back bytes
        load(8'h01, 9, 8'h01);
        send_buf(1'b0);
        chk("t1_latency", cmd_valid, 1'b1);
        chk("t1_sel", cmd_select, 16'h1);
        chk("t1_data", cmd_data, 264'h01);
        repeat (3) @(posedge clk); #1;
        chk("t1_hold", cmd_valid, 1'b1);
        ack();
        chk("t1_drop", cmd_valid, 1'b0);
        chk("t1_ready", rx_ready, 1'b1);

        // 2: read yaw, held with back-pressure
        load(8'h03, 8, 8'h00);
        send_buf(1'b0);
        chk("t2_sel", cmd_select, 16'h2);
        chk("t2_data", cmd_data, 264'h0);
        rx_valid = 1'b1;
        rx_byte  = 8'hAA;
        repeat (20) @(posedge clk); #1;
        chk("t2_hold", cmd_valid, 1'b1);
        chk("t2_bp", rx_ready, 1'b0);
        rx_valid = 1'b0;
        ack();
        chk("t2_busy", busy, 1'b0);

        // 3: unknown ID swallowed, then a good frame
        load(8'h7F, 8, 8'h00);
        send_buf(1'b0);
        chk("t3_err", error, 1'b1);
        chk("t3_code", err_code, 2'd1);
        chk("t3_nocmd", cmd_valid, 1'b0);
        @(posedge clk); #1;
        chk("t3_pulse", error, 1'b0);
        load(8'h03, 8, 8'h00);
        send_buf(1'b0);
        chk("t3_sel", cmd_select, 16'h2);
        ack();

        // 4: inter-byte timeout
        load(8'h01, 3, 8'h00);
        send_buf(1'b0);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (error) begin
                cyc = i;
                break;
            end
        end
        chk("t4_cycles", cyc, 16);
        chk("t4_code", err_code, 2'd2);
        load(8'h01, 9, 8'h5A);
        send_buf(1'b0);
        chk("t4_sel", cmd_select, 16'h1);
        chk("t4_data", cmd_data, 264'h5A);
        ack();

        // 5: rx_valid toggled every other cycle
        load(8'h01, 9, 8'h00);
        send_buf(1'b1);
        chk("t5_sel", cmd_select, 16'h1);
        chk("t5_data", cmd_data, 264'h0);
        chk("t5_code", err_code, 2'd2);
        ack();

        // 6: reset after the 5th byte
        load(8'h01, 5, 8'h00);
        send_buf(1'b0);
        chk("t6_busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("t6");
        @(posedge clk); #1;
        reset = 1'b0;
        load(8'h01, 9, 8'hC3);
        send_buf(1'b0);
        chk("t6_sel", cmd_select, 16'h1);
        chk("t6_data", cmd_data, 264'hC3);
        ack();
        repeat (3) @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/host_uart_command_dec.md
Name: host_uart_command_dec

Overview:
Receive-side companion of the host UART response encoder. Accepts the byte stream from the UART RX path, assembles host command frames, and validates the command ID. Presents each decoded command to the command handler as a held cmd_select/cmd_data pair. The cmd_select codes are the ones the response encoder consumes, so a handler can pass cmd_select straight through to build the reply.

Parameters:
HDR_BYTES, 8, fixed frame header length in bytes: byte0 = command ID, bytes1..7 reserved and ignored.
ENCRYPT_ENABLE_CMD_ID, 8'h01, ID of the enable/disable-encryption command; payload 1 byte.
READ_YAW_CMD_ID, 8'h03, ID of the read-yaw command; payload 0 bytes.
TIMEOUT_CYCLES, 100000, maximum idle clk cycles between bytes inside a frame before abort.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_byte  input  8  received UART byte
rx_valid  input  1  rx_byte valid; a byte transfers on a clk edge where rx_valid && rx_ready
rx_ready  output  1  decoder can accept a byte
cmd_valid  output  1  decoded command available; held until acknowledged
cmd_select  output  16  16'h1 = encrypt enable, 16'h2 = read yaw; stable while cmd_valid
cmd_data  output  264  payload, byte k at bits [8k+7:8k], unused bits zero
cmd_ack  input  1  handler consumes the command; sampled only while cmd_valid
busy  output  1  a frame is in progress or a command is held
error  output  1  one-cycle pulse on a frame error
err_code  output  2  1 = unknown ID, 2 = inter-byte timeout; holds last value until next error

Behaviour:
- Reset (asynchronous): all outputs 0 except rx_ready = 1. State = IDLE, counters 0, cmd_data 0.
- IDLE:
  - On a byte transfer, latch the byte as ID.
  - Map the ID: 0x01 → sel 1, payload length 1; 0x03 → sel 2, payload length 0; any other ID → unknown flag set.
  - Clear the cmd_data accumulator, set byte count = 1, go to HDR.
- HDR: consume bytes until HDR_BYTES header bytes are received (byte count wraps at HDR_BYTES). On the last header byte:
  - unknown ID → pulse error for one cycle, err_code = 1, return to IDLE (the frame is swallowed);
  - payload length 0 → go to DONE;
  - otherwise → go to PAYLOAD.
- PAYLOAD: byte k (0-based) is written to accumulator bits [8k+7:8k]. After the last payload byte, go to DONE.
- DONE: cmd_valid = 1, cmd_select and cmd_data driven from registers, rx_ready = 0.
  - On a cycle with cmd_ack = 1, cmd_valid drops on the next edge and state returns to IDLE; rx_ready = 1 from then on.
  - Minimum latency from the last frame byte transfer to cmd_valid is 1 cycle.
- rx_ready = 1 in IDLE, HDR and PAYLOAD; rx_ready = 0 in DONE.
- busy = 1 in any state other than IDLE.
- Timeout:
  - In HDR and PAYLOAD, a counter increments on every cycle without a transfer and clears on each transfer.
  - When it reaches TIMEOUT_CYCLES-1 without a transfer: pulse error, err_code = 2, discard the partial frame, go to IDLE.
  - The counter is inactive in IDLE and DONE.
- Simultaneous events:
  - A byte transfer and timeout expiry in the same cycle: the transfer wins and the counter clears.
  - cmd_ack outside DONE is ignored.
  - rx_valid in DONE is not accepted (back-pressure); the byte is presented again by the source.
- Reset mid-frame or mid-hold: immediate return to reset values; cmd_valid drops with no ack required.
- cmd_data bits above the payload length read 0.
- The error pulse never coincides with cmd_valid.

Decomposition:
- Shared package host_uart_cmd_pkg holds:
  - the command/response ID constants (0x01, 0x02, 0x03, 0x04);
  - the cmd_select codes (16'h1, 16'h2);
  - the err_code enumeration;
  - the state enumeration (IDLE, HDR, PAYLOAD, DONE).
- The encoder imports the same package.
- One sub-module, uart_byte_timeout: counter with clear/enable/expire, parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Bytes 01 00 00 00 00 00 00 00 01, continuous, no stalls → cmd_valid 1 cycle after the 9th byte; cmd_select = 16'h1; cmd_data = 264'h01; held until cmd_ack, then rx_ready = 1.
2. Bytes 03 + 7×00 → cmd_select = 16'h2, cmd_data = 0. Hold cmd_ack = 0 for 20 cycles → cmd_valid stays high, rx_ready = 0, a presented byte is not consumed.
3. Bytes 7F + 7×00 → one-cycle error pulse with err_code = 1, no cmd_valid. A following valid frame 03 + 7×00 decodes correctly.
4. TIMEOUT_CYCLES = 16; send 01 00 00, then stop → error pulse with err_code = 2 sixteen cycles after the last byte. The next frame decodes from a fresh header.
5. Frame 01 + 7×00 + 00 with rx_valid toggled every other cycle → cmd_select = 16'h1, cmd_data = 0, no timeout.
6. Assert reset after the 5th byte of a frame → all outputs return to reset values immediately. A complete frame after release decodes normally.
